// File: rtl/axis_mem_requester.sv
// axis_mem_requester
// Request-side master for the shared AXI-Stream memory block. One client
// transaction at a time is turned into CMD / ADDR / (DATA) beats on m_axis.
// The single response beat is taken from s_axis and returned on the rsp_*
// port. A wait timeout produces an errored response. Unsolicited beats seen
// while idle are dropped and counted.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   req_valid/ready        client request handshake
//   req_write/addr/wdata   request fields, captured at the handshake
//   rsp_valid/ready        client response handshake
//   rsp_data/error/write   response fields, stable while rsp_valid
//   stray_cnt              saturating count of discarded idle beats
//   m_axis_*               request beats to memory (tdest constant DEST)
//   s_axis_*               response beats from memory (tlast unused)
module axis_mem_requester #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [1:0]  DEST           = 2'd0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_write,
  output logic [7:0]            stray_cnt,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            m_axis_tdest,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    SEND_ADDR = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_RSP  = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic [DATA_WIDTH-1:0]   beat_data_d;
  logic                    beat_last_d;
  logic                    req_hs, m_hs, s_hs, rsp_hs, timeout_hit;
  logic                    tlast_unused;

  // Every response is one beat, so the incoming tlast carries no information.
  assign tlast_unused = s_axis_tlast;

  // Handshakes are formed from the registered outputs actually driven.
  assign req_hs = req_valid && req_ready;
  assign m_hs   = m_axis_tvalid && m_axis_tready;
  assign s_hs   = s_axis_tvalid && s_axis_tready;
  assign rsp_hs = rsp_valid && rsp_ready;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, request capture and the next beat to present.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat_data_d = '0;
    beat_last_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d = SEND_CMD;
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      SEND_CMD:  if (m_hs) state_d = SEND_ADDR;
      SEND_ADDR: if (m_hs) state_d = wr_q ? SEND_DATA : WAIT_RSP;
      SEND_DATA: if (m_hs) state_d = WAIT_RSP;
      // A beat in the timeout cycle still wins; both paths lead to RESP.
      WAIT_RSP:  if (s_hs || timeout_hit) state_d = RESP;
      RESP:      if (rsp_hs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Beat fields follow the next state so they are ready as tvalid rises
    // and hold unchanged while stalled.
    case (state_d)
      SEND_CMD:  beat_data_d = DATA_WIDTH'(wr_d);
      SEND_ADDR: begin
        beat_data_d = DATA_WIDTH'(addr_d);
        beat_last_d = !wr_d;
      end
      SEND_DATA: begin
        beat_data_d = wdata_d;
        beat_last_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered port outputs decoded from the next state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      req_ready     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= 2'd0;
      s_axis_tready <= 1'b0;
      rsp_valid     <= 1'b0;
    end else begin
      req_ready     <= (state_d == IDLE);
      m_axis_tvalid <= (state_d == SEND_CMD) || (state_d == SEND_ADDR) ||
                       (state_d == SEND_DATA);
      m_axis_tdata  <= beat_data_d;
      m_axis_tlast  <= beat_last_d;
      m_axis_tdest  <= DEST;
      s_axis_tready <= (state_d == IDLE) || (state_d == WAIT_RSP);
      rsp_valid     <= (state_d == RESP);
    end
  end

  // Request capture, wait counter, response fields and stray counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      rsp_write  <= 1'b0;
      stray_cnt  <= 8'd0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;

      // Zero in the first WAIT_RSP cycle, then counts up.
      if (state_q == WAIT_RSP) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else                     wait_cnt_q <= '0;

      if (state_q == WAIT_RSP) begin
        if (s_hs) begin
          rsp_data  <= s_axis_tdata;
          rsp_error <= wr_q && (s_axis_tdata != DATA_WIDTH'(1));
          rsp_write <= wr_q;
        end else if (timeout_hit) begin
          rsp_data  <= '0;
          rsp_error <= 1'b1;
          rsp_write <= wr_q;
        end
      end

      if ((state_q == IDLE) && s_hs && (stray_cnt != 8'hFF))
        stray_cnt <= stray_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_axis_mem_requester.sv
// Directed and randomized-backpressure bench for axis_mem_requester with a
// behavioral memory responder and a reference memory for expected read data.
module tb_axis_mem_requester;

  localparam int DW = 64;
  localparam int AW = 8;

  logic          aclk, aresetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_write;
  logic [DW-1:0] rsp_data;
  logic [7:0]    stray_cnt;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]    m_axis_tdest;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;

  axis_mem_requester #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEST(2'd0), .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_write(rsp_write), .stray_cnt(stray_cnt),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder configuration, written by the main sequence.
  int          tr_mode   = 0;   // 0 ready always, 1 random, 2 accept two beats then stall
  int          rsp_delay = 0;
  bit          no_rsp    = 0;
  bit          stray_req = 0;
  logic [63:0] ack_val   = 64'd1;

  logic [63:0] slv_mem [256];
  logic [63:0] ref_mem [256];

  // Log of accepted request beats for the current transaction.
  logic [63:0] bl_data [$];
  logic        bl_last [$];
  int          bl_cyc  [$];
  int          rsp_hs_cyc = 0;

  // Memory responder: all decisions at the falling edge.
  initial begin
    logic [63:0] cur [$];
    logic [63:0] prev_data;
    logic [63:0] rsp_word;
    logic        prev_last, prev_stall, s_hs_flag, rsp_pend;
    int          rsp_cnt;
    prev_data = '0; prev_last = 1'b0; prev_stall = 1'b0; s_hs_flag = 1'b0;
    rsp_pend = 1'b0; rsp_cnt = 0; rsp_word = '0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        cur.delete(); rsp_pend = 1'b0; prev_stall = 1'b0; s_hs_flag = 1'b0;
      end else begin
        if (s_hs_flag) begin
          s_axis_tvalid = 1'b0;
          s_axis_tlast  = 1'b0;
        end
        if (prev_stall) begin
          chk("beat_hold_valid", 64'(m_axis_tvalid), 64'd1);
          chk("beat_hold_data", m_axis_tdata, prev_data);
          chk("beat_hold_last", 64'(m_axis_tlast), 64'(prev_last));
        end
        case (tr_mode)
          1:       m_axis_tready = ($urandom_range(0, 1) == 1);
          2:       m_axis_tready = (cur.size() < 2);
          default: m_axis_tready = 1'b1;
        endcase
        if (m_axis_tvalid && m_axis_tready) begin
          bl_data.push_back(m_axis_tdata);
          bl_last.push_back(m_axis_tlast);
          bl_cyc.push_back(cyc);
          cur.push_back(m_axis_tdata);
          if (m_axis_tlast) begin
            if (cur.size() >= 2 && cur[0] == 64'd1 && cur.size() >= 3) begin
              slv_mem[cur[1][7:0]] = cur[2];
              rsp_word = ack_val;
            end else begin
              rsp_word = slv_mem[cur[1][7:0]];
            end
            if (!no_rsp) begin
              rsp_pend = 1'b1;
              rsp_cnt  = (tr_mode == 1) ? $urandom_range(0, 4) : rsp_delay;
            end
            cur.delete();
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (!s_axis_tvalid) begin
          if (rsp_pend) begin
            if (rsp_cnt == 0) begin
              s_axis_tvalid = 1'b1; s_axis_tdata = rsp_word; s_axis_tlast = 1'b1;
              rsp_pend = 1'b0;
            end else begin
              rsp_cnt--;
            end
          end else if (stray_req) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 64'h77; s_axis_tlast = 1'b1;
            stray_req = 1'b0;
          end
        end
        s_hs_flag = s_axis_tvalid && s_axis_tready;
        if (s_hs_flag) rsp_hs_cyc = cyc;
      end
    end
  end

  function automatic logic any_out();
    return |{req_ready, rsp_valid, rsp_data, rsp_error, rsp_write, stray_cnt,
             m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest, s_axis_tready};
  endfunction

  // One client transaction; expected response from the reference memory.
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [63:0] wd,
                         input bit bp, input bit exp_to, output int req_c, output int rsp_c);
    logic [63:0] ed, eb [3];
    logic        ee;
    int          n, nb;
    if (exp_to) begin
      ed = '0; ee = 1'b1;
    end else if (wr) begin
      ed = ack_val; ee = (ack_val != 64'd1); ref_mem[addr] = wd;
    end else begin
      ed = ref_mem[addr]; ee = 1'b0;
    end
    eb[0] = wr ? 64'd1 : 64'd0; eb[1] = 64'(addr); eb[2] = wd; nb = wr ? 3 : 2;
    bl_data.delete(); bl_last.delete(); bl_cyc.delete();
    n = 0;
    while (!req_ready && n < 100) begin @(negedge aclk); n++; end
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_c = cyc;
    @(negedge aclk);
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_write = ~wr;
    rsp_c = -1; n = 0;
    while (n < 200) begin
      if (rsp_valid && rsp_c < 0) rsp_c = cyc;
      rsp_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rsp_valid && rsp_ready) break;
      @(negedge aclk); n++;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_error", 64'(rsp_error), 64'(ee));
    chk("rsp_write", 64'(rsp_write), 64'(wr));
    @(negedge aclk);
    rsp_ready = 1'b0;
    if (!bp) chk("req_ready_after_rsp", 64'(req_ready), 64'd1);
    chk("beat_count", 64'(bl_data.size()), 64'(nb));
    for (int i = 0; i < nb && i < bl_data.size(); i++) begin
      chk("beat_data", bl_data[i], eb[i]);
      chk("beat_last", 64'(bl_last[i]), 64'(i == nb - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq, rs, n;
    bit w;
    logic [7:0]  a;
    logic [63:0] d;
    aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

    // Reset state and first cycle after release.
    repeat (2) @(negedge aclk);
    chk("rst_outs_zero", 64'(any_out()), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_req_ready", 64'(req_ready), 64'd1);
    chk("rel_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rel_tdest", 64'(m_axis_tdest), 64'd0);

    // Directed write, memory ACKs with 1.
    run_txn(1'b1, 8'h05, 64'hDEAD_BEEF, 1'b0, 1'b0, rq, rs);
    for (int i = 0; i < 3 && i < bl_cyc.size(); i++)
      chk("wr_beat_cycle", 64'(bl_cyc[i]), 64'(rq + 1 + i));

    // Directed read with delayed response.
    rsp_delay = 3;
    run_txn(1'b0, 8'h05, 64'h0, 1'b0, 1'b0, rq, rs);
    chk("rd_rsp_after_beat", 64'(rs), 64'(rsp_hs_cyc + 1));
    for (int i = 0; i < 2 && i < bl_cyc.size(); i++)
      chk("rd_beat_cycle", 64'(bl_cyc[i]), 64'(rq + 1 + i));
    rsp_delay = 0;

    // Timeout: read with no response, then a late beat counted as stray.
    no_rsp = 1'b1;
    run_txn(1'b0, 8'h05, 64'h0, 1'b0, 1'b1, rq, rs);
    chk("to_latency", 64'(rs), 64'(rq + 11));
    no_rsp = 1'b0;
    stray_req = 1'b1;
    repeat (4) @(negedge aclk);
    chk("stray_after_to", 64'(stray_cnt), 64'd1);

    // Write ACK of 2 is an error; data still lands in memory.
    ack_val = 64'd2;
    run_txn(1'b1, 8'h09, 64'h1234, 1'b0, 1'b0, rq, rs);
    ack_val = 64'd1;
    run_txn(1'b0, 8'h09, 64'h0, 1'b0, 1'b0, rq, rs);

    // Mixed traffic under random backpressure on both sides.
    tr_mode = 1;
    for (int t = 0; t < 200; t++) begin
      w = ($urandom_range(0, 1) == 1);
      a = 8'($urandom_range(0, 15));
      d = {$urandom(), $urandom()};
      run_txn(w, a, d, 1'b1, 1'b0, rq, rs);
    end
    tr_mode = 0;
    repeat (3) @(negedge aclk);
    chk("stray_final", 64'(stray_cnt), 64'd1);

    // Reset while the DATA beat is stalled.
    tr_mode = 2;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h03; req_wdata = 64'hABCD;
    @(negedge aclk);
    req_valid = 1'b0;
    n = 0;
    while (!(m_axis_tvalid && m_axis_tlast) && n < 20) begin @(negedge aclk); n++; end
    chk("reach_send_data", m_axis_tdata, 64'hABCD);
    aresetn = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      chk("mid_rst_outs_zero", 64'(any_out()), 64'd0);
    end
    tr_mode = 0;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel2_req_ready", 64'(req_ready), 64'd1);
    chk("rel2_stray", 64'(stray_cnt), 64'd0);
    rsp_ready = 1'b1;
    repeat (5) begin
      chk("rel2_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge aclk);
    end
    rsp_ready = 1'b0;
    run_txn(1'b0, 8'h03, 64'h0, 1'b0, 1'b0, rq, rs);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_mem_requester.md
# axis_mem_requester

Request-side master that drives the shared AXI-Stream memory block. It converts a simple client read/write request into the memory's beat protocol: a CMD beat, an ADDR beat, and a DATA beat for writes only. It then waits for the single response beat and returns it to the client. Only one transaction is outstanding at a time, a response timeout is enforced, and stray response beats arriving while idle are discarded.

## Interface
- DATA_WIDTH, 64, stream and data word width
- ADDR_WIDTH, 8, client address width; zero-extended into the ADDR beat
- DEST, 2'd0, constant value driven on m_axis_tdest
- TIMEOUT_CYCLES, 64, response wait limit in cycles; 0 disables the timeout
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- req_valid  in  1  client request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts the response
- rsp_data  out  DATA_WIDTH  read data or write ACK word; 0 on timeout
- rsp_error  out  1  timeout, or write ACK not equal to 1
- rsp_write  out  1  echo of req_write for this transaction
- stray_cnt  out  8  saturating count of discarded unsolicited response beats
- m_axis_tdata  out  DATA_WIDTH  request beat
- m_axis_tvalid  out  1  request beat valid
- m_axis_tready  in  1  memory ready
- m_axis_tlast  out  1  high on the last beat of a request
- m_axis_tdest  out  2  always DEST
- s_axis_tdata  in  DATA_WIDTH  response beat
- s_axis_tvalid  in  1  response valid
- s_axis_tready  out  1  block accepts a response beat
- s_axis_tlast  in  1  ignored; every response is a single beat

## Operation
- States: IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_RSP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, capture write/addr/wdata, then go to SEND_CMD.
  - s_axis_tready=1. Any beat accepted here is dropped and stray_cnt increments, saturating at 255.
- SEND_CMD:
  - tdata = 1 for a write, 0 for a read, zero-extended to DATA_WIDTH; tlast=0.
  - On handshake, go to SEND_ADDR.
- SEND_ADDR:
  - tdata = {zeros, addr}.
  - Read: tlast=1, and the handshake moves to WAIT_RSP.
  - Write: tlast=0, and the handshake moves to SEND_DATA.
- SEND_DATA:
  - tdata = wdata, tlast=1.
  - On handshake, go to WAIT_RSP.
- WAIT_RSP:
  - s_axis_tready=1. The wait counter clears on entry and increments by 1 each cycle.
  - On an accepted beat: capture rsp_data = s_axis_tdata, then go to RESP.
  - rsp_error = write && (s_axis_tdata != 1). Reads are never errored by data.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 with no beat, go to RESP with rsp_data=0 and rsp_error=1.
- RESP:
  - rsp_valid=1; all fields hold stable until rsp_ready.
  - On handshake, go to IDLE.
- m_axis_tvalid is high only in the SEND_* states. The beat fields hold stable while tvalid && !tready.
- s_axis_tready=0 in all SEND_* states and in RESP.
- A response arriving after a timeout lands in IDLE and counts as stray. It is never attributed to the next request.

## Timing
- Reset:
  - While aresetn=0: state=IDLE, stray_cnt=0, and every output is 0, including req_ready and s_axis_tready.
  - req_ready rises in the first cycle after aresetn deasserts.
  - Reset asserted in any state aborts the transaction silently; no rsp is produced.
- Latency with m_axis_tready held at 1:
  - Read: request handshake at cycle 0, CMD beat at cycle 1, ADDR beat at cycle 2, WAIT_RSP from cycle 3.
  - Write: adds a DATA beat at cycle 3, WAIT_RSP from cycle 4.
- rsp_valid asserts in the cycle after the response beat handshake or the timeout.
- With rsp_ready=1, req_ready returns in the cycle after rsp_valid.
- Timeout boundary: a response beat in the same cycle the counter hits TIMEOUT_CYCLES-1 wins, giving a normal response with no error.
- Back-to-back: each request costs a minimum of 1 + beats + memory latency + 2 cycles. There is no overlap between transactions.

## Test plan
- Write addr 0x05, data 0xDEAD_BEEF; memory returns 1:
  - Beats 1, 5, DEADBEEF; tlast only on the 3rd beat.
  - rsp_data=1, rsp_error=0, rsp_write=1.
- Read addr 0x05 after a 3-cycle response delay, returned data 0xDEAD_BEEF:
  - Beats 0, 5; tlast on the ADDR beat.
  - rsp_data=0xDEADBEEF, rsp_error=0.
- Random m_axis_tready and rsp_ready backpressure over 200 mixed transactions:
  - Beats are stable while stalled and no beat is lost.
  - Responses are in order and match a reference memory model.
- TIMEOUT_CYCLES=8, read with no response:
  - rsp_valid at exactly 8 cycles after WAIT_RSP entry, with rsp_error=1 and rsp_data=0.
  - A late beat then increments stray_cnt to 1.
- Write ACK returned as 0x2: rsp_error=1, rsp_data=2.
- Reset asserted mid-SEND_DATA: all outputs 0 during reset, no rsp is produced, and req_ready=1 on the first cycle after release.
